// File: rtl/netlist_vector_sequencer.sv
// Plays stored stimulus vectors from a vector memory into a DUT, 3 cycles per vector.
// Also accumulates the Hamming distance between consecutive DUT responses.
module netlist_vector_sequencer #(
    parameter int NUM_IO = 62,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_vec,
    input  logic              hold,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [NUM_IO+1:0] mem_rdata,
    output logic [NUM_IO-1:0] dut_in,
    output logic              dut_rst,
    input  logic [NUM_IO-1:0] dut_out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] vec_idx,
    output logic [CNT_W-1:0]  toggle_cnt
);

    localparam int POP_W = $clog2(NUM_IO + 1);
    // The sum is wide enough for both operands, so the saturation test never sees a wrapped value.
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   num_vec_q, num_vec_d;
    logic [ADDR_W-1:0]   vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0]    toggle_q, toggle_d;
    logic [NUM_IO-1:0]   last_out_q, last_out_d;
    logic                first_q, first_d;
    logic [NUM_IO-1:0]   dut_in_q, dut_in_d;
    logic                dut_rst_q, dut_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [NUM_IO-1:0]   diff;
    logic [POP_W-1:0]    pop;
    logic [SUM_W-1:0]    sum;
    logic [CNT_W-1:0]    toggle_inc;
    logic [ADDR_W-1:0]   vec_idx_inc;
    logic                unused_msb;

    assign unused_msb = mem_rdata[NUM_IO+1];

    assign diff = dut_out ^ last_out_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            pop = pop + POP_W'(diff[i]);
        end
    end

    assign sum         = SUM_W'(toggle_q) + SUM_W'(pop);
    assign toggle_inc  = (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    assign vec_idx_inc = vec_idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        num_vec_d  = num_vec_q;
        vec_idx_d  = vec_idx_q;
        toggle_d   = toggle_q;
        last_out_d = last_out_q;
        first_d    = first_q;
        dut_in_d   = dut_in_q;
        dut_rst_d  = dut_rst_q;
        mem_rd     = 1'b0;
        mem_addr   = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_idx_d = '0;
                    toggle_d  = '0;
                    first_d   = 1'b1;
                    num_vec_d = num_vec;
                    state_d   = (num_vec == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (!hold) begin
                    mem_rd   = 1'b1;
                    mem_addr = vec_idx_q;
                    state_d  = S_APPLY;
                end
            end
            S_APPLY: begin
                dut_in_d  = mem_rdata[NUM_IO:1];
                dut_rst_d = mem_rdata[0];
                state_d   = S_CAPTURE;
            end
            S_CAPTURE: begin
                // The first response of a run has no predecessor to compare against.
                last_out_d = dut_out;
                first_d    = 1'b0;
                if (!first_q) begin
                    toggle_d = toggle_inc;
                end
                vec_idx_d = vec_idx_inc;
                state_d   = (vec_idx_inc == num_vec_q) ? S_DONE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_APPLY) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            num_vec_q  <= '0;
            vec_idx_q  <= '0;
            toggle_q   <= '0;
            last_out_q <= '0;
            first_q    <= 1'b0;
            dut_in_q   <= '0;
            dut_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_vec_q  <= num_vec_d;
            vec_idx_q  <= vec_idx_d;
            toggle_q   <= toggle_d;
            last_out_q <= last_out_d;
            first_q    <= first_d;
            dut_in_q   <= dut_in_d;
            dut_rst_q  <= dut_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign dut_rst    = dut_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign vec_idx    = vec_idx_q;
    assign toggle_cnt = toggle_q;

endmodule
